// File: rtl/mandel_engine.sv
// Mandelbrot iteration engine: takes one complex point c with its pixel tag,
// iterates z <- z^2 + c from z = 0 until |z|^2 > 4 or the iteration cap, and
// reports the final count with a one-cycle done pulse.
module mandel_engine #(
  parameter int FIXED_WIDTH      = 32,
  parameter int FRAC_BITS        = 28,
  parameter int DATA_WIDTH       = 10,
  parameter int ITERATIONS_WIDTH = 6,
  parameter int MAX_ITERATION    = 50
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [FIXED_WIDTH-1:0]      c_re,
  input  logic [FIXED_WIDTH-1:0]      c_im,
  input  logic [DATA_WIDTH-1:0]       in_x,
  input  logic [DATA_WIDTH-1:0]       in_y,
  output logic                        busy,
  output logic                        done,
  output logic [ITERATIONS_WIDTH-1:0] iterations,
  output logic [DATA_WIDTH-1:0]       out_x,
  output logic [DATA_WIDTH-1:0]       out_y
);

  localparam int PW = 2 * FIXED_WIDTH;

  // 4.0 expressed at full product width (one guard bit for the sum).
  localparam logic signed [PW:0] ESCAPE_LIMIT = (PW+1)'(4) << FRAC_BITS;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ITERATE,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_nextState;
  logic   w_accept;

  logic signed [FIXED_WIDTH-1:0] r_zRe;
  logic signed [FIXED_WIDTH-1:0] r_zIm;
  logic signed [FIXED_WIDTH-1:0] r_cRe;
  logic signed [FIXED_WIDTH-1:0] r_cIm;
  logic [ITERATIONS_WIDTH-1:0]   r_n;
  logic [DATA_WIDTH-1:0]         r_tagX;
  logic [DATA_WIDTH-1:0]         r_tagY;
  logic [ITERATIONS_WIDTH-1:0]   r_iterations;
  logic [DATA_WIDTH-1:0]         r_outX;
  logic [DATA_WIDTH-1:0]         r_outY;

  logic signed [PW-1:0]          w_prodRe;
  logic signed [PW-1:0]          w_prodIm;
  logic signed [PW-1:0]          w_prodRi;
  logic signed [PW-1:0]          w_zr2;
  logic signed [PW-1:0]          w_zi2;
  logic signed [PW-1:0]          w_zri;
  logic signed [PW-1:0]          w_cReExt;
  logic signed [PW-1:0]          w_cImExt;
  logic signed [PW:0]            w_magSq;
  logic                          w_escape;
  logic                          w_atMax;
  logic                          w_finish;
  logic signed [FIXED_WIDTH-1:0] w_nextRe;
  logic signed [FIXED_WIDTH-1:0] w_nextIm;

  // Squares and cross product of the current z, rescaled back to the
  // fixed-point grid, plus the escape test kept at full width so a large
  // |z|^2 can never wrap into a false "inside" result.
  always_comb begin
    w_prodRe = r_zRe * r_zRe;
    w_prodIm = r_zIm * r_zIm;
    w_prodRi = r_zRe * r_zIm;
    w_zr2    = w_prodRe >>> FRAC_BITS;
    w_zi2    = w_prodIm >>> FRAC_BITS;
    w_zri    = w_prodRi >>> FRAC_BITS;
    w_cReExt = {{FIXED_WIDTH{r_cRe[FIXED_WIDTH-1]}}, r_cRe};
    w_cImExt = {{FIXED_WIDTH{r_cIm[FIXED_WIDTH-1]}}, r_cIm};
    w_magSq  = {w_zr2[PW-1], w_zr2} + {w_zi2[PW-1], w_zi2};
    w_escape = (w_magSq > ESCAPE_LIMIT);
    w_atMax  = (r_n == ITERATIONS_WIDTH'(MAX_ITERATION));
    w_finish = w_escape || w_atMax;
    w_nextRe = FIXED_WIDTH'(w_zr2 - w_zi2 + w_cReExt);
    w_nextIm = FIXED_WIDTH'((w_zri <<< 1) + w_cImExt);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic; a new point may be accepted from IDLE or straight out
  // of DONE so consecutive points run without an idle gap.
  always_comb begin
    w_nextState = r_state;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_nextState = S_ITERATE;
          w_accept    = 1'b1;
        end
      end
      S_ITERATE: begin
        if (w_finish) begin
          w_nextState = S_DONE;
        end
      end
      S_DONE: begin
        if (start) begin
          w_nextState = S_ITERATE;
          w_accept    = 1'b1;
        end else begin
          w_nextState = S_IDLE;
        end
      end
      default: begin
        w_nextState = S_IDLE;
      end
    endcase
  end

  // Datapath: latch the point on acceptance, step z each ITERATE cycle, and
  // publish count and tags on the way into DONE (held until the next result).
  always_ff @(posedge clk) begin
    if (reset) begin
      r_zRe        <= '0;
      r_zIm        <= '0;
      r_cRe        <= '0;
      r_cIm        <= '0;
      r_n          <= '0;
      r_tagX       <= '0;
      r_tagY       <= '0;
      r_iterations <= '0;
      r_outX       <= '0;
      r_outY       <= '0;
    end else if (w_accept) begin
      r_cRe  <= c_re;
      r_cIm  <= c_im;
      r_tagX <= in_x;
      r_tagY <= in_y;
      r_zRe  <= '0;
      r_zIm  <= '0;
      r_n    <= '0;
    end else if (r_state == S_ITERATE) begin
      if (w_finish) begin
        r_iterations <= r_n;
        r_outX       <= r_tagX;
        r_outY       <= r_tagY;
      end else begin
        r_zRe <= w_nextRe;
        r_zIm <= w_nextIm;
        r_n   <= r_n + 1'b1;
      end
    end
  end

  assign busy       = (r_state == S_ITERATE);
  assign done       = (r_state == S_DONE);
  assign iterations = r_iterations;
  assign out_x      = r_outX;
  assign out_y      = r_outY;

endmodule

// File: tb/tb_mandel_engine.sv
// Directed testbench for mandel_engine: hand-computed orbits, latency,
// tag pass-through, ignored mid-iteration starts, back-to-back points and
// reset abort.
module tb_mandel_engine;

  localparam logic [31:0] ZERO    = 32'h0000_0000;
  localparam logic [31:0] ONE     = 32'h1000_0000;
  localparam logic [31:0] HALF    = 32'h0800_0000;
  localparam logic [31:0] TWO     = 32'h2000_0000;
  localparam logic [31:0] NEG_ONE = 32'hF000_0000;
  localparam logic [31:0] NEG_TWO = 32'hE000_0000;
  localparam int          LIMIT   = 200;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] c_re;
  logic [31:0] c_im;
  logic [9:0]  in_x;
  logic [9:0]  in_y;
  logic        busy;
  logic        done;
  logic [5:0]  iterations;
  logic [9:0]  out_x;
  logic [9:0]  out_y;

  int checks   = 0;
  int failures = 0;

  mandel_engine dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .c_re       (c_re),
    .c_im       (c_im),
    .in_x       (in_x),
    .in_y       (in_y),
    .busy       (busy),
    .done       (done),
    .iterations (iterations),
    .out_x      (out_x),
    .out_y      (out_y)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Called at a falling edge (that cycle is "cycle 0"). Starts a point, waits
  // for done within a bound and checks latency, busy span, count and tags.
  // Optionally pulses start with a different point during ITERATE.
  // Returns at the falling edge of the done cycle.
  task automatic applyStimulus(input string tag, input logic [31:0] cre, input logic [31:0] cim,
                               input logic [9:0] x, input logic [9:0] y,
                               input int expIter, input int glitchAt);
    int lat;
    int busyCount;
    start = 1'b1;
    c_re  = cre;
    c_im  = cim;
    in_x  = x;
    in_y  = y;
    @(negedge clk);
    lat       = 1;
    busyCount = 0;
    while (!done && lat < LIMIT) begin
      if (busy) busyCount++;
      if (lat == glitchAt) begin
        start = 1'b1;
        c_re  = ONE;
        c_im  = ONE;
        in_x  = 10'd999;
        in_y  = 10'd998;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    checkOutput({tag, "_latency"}, 64'(lat), 64'(expIter + 2));
    checkOutput({tag, "_busy_cycles"}, 64'(busyCount), 64'(expIter + 1));
    checkOutput({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    checkOutput({tag, "_iterations"}, 64'(iterations), 64'(expIter));
    checkOutput({tag, "_out_x"}, 64'(out_x), 64'(x));
    checkOutput({tag, "_out_y"}, 64'(out_y), 64'(y));
  endtask

  initial begin
    int doneCount;
    reset = 1'b1;
    start = 1'b0;
    c_re  = ZERO;
    c_im  = ZERO;
    in_x  = '0;
    in_y  = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_done", 64'(done), 64'd0);
    checkOutput("reset_iterations", 64'(iterations), 64'd0);
    checkOutput("reset_out_x", 64'(out_x), 64'd0);
    checkOutput("reset_out_y", 64'(out_y), 64'd0);
    reset = 1'b0;

    // Origin never escapes: full cap, done exactly once.
    applyStimulus("origin", ZERO, ZERO, 10'd3, 10'd7, 50, 0);
    @(negedge clk);
    checkOutput("origin_done_one_cycle", 64'(done), 64'd0);
    checkOutput("origin_iter_held", 64'(iterations), 64'd50);

    // 1+1i escapes at n = 2, then 0.5 starts in the done cycle (no gap).
    applyStimulus("c_1_1", ONE, ONE, 10'd11, 10'd12, 2, 0);
    applyStimulus("c_half_b2b", HALF, ZERO, 10'd4, 10'd5, 5, 0);
    @(negedge clk);

    // |z|^2 == 4 exactly is not an escape.
    applyStimulus("c_neg2", NEG_TWO, ZERO, 10'd20, 10'd21, 50, 0);
    @(negedge clk);
    applyStimulus("c_neg1", NEG_ONE, ZERO, 10'd22, 10'd23, 50, 0);
    @(negedge clk);
    // Imaginary axis: 0, 2i, -4+2i -> escapes at n = 2.
    applyStimulus("c_0_2i", ZERO, TWO, 10'd1023, 10'd0, 2, 0);
    @(negedge clk);

    // Start pulse mid-iteration with a different point is ignored.
    applyStimulus("ignore_start", ZERO, ZERO, 10'd1, 10'd2, 50, 5);
    @(negedge clk);

    // Reset in cycle 10 of an origin point: outputs clear, no done follows.
    start = 1'b1;
    c_re  = ZERO;
    c_im  = ZERO;
    in_x  = 10'd30;
    in_y  = 10'd31;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("abort_busy", 64'(busy), 64'd0);
    checkOutput("abort_done", 64'(done), 64'd0);
    checkOutput("abort_iterations", 64'(iterations), 64'd0);
    checkOutput("abort_out_x", 64'(out_x), 64'd0);
    checkOutput("abort_out_y", 64'(out_y), 64'd0);
    doneCount = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done || busy) doneCount++;
    end
    checkOutput("abort_no_activity", 64'(doneCount), 64'd0);

    // Normal operation resumes after the abort.
    applyStimulus("after_reset", ONE, ONE, 10'd40, 10'd41, 2, 0);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
